// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the unified-RAM arbiter: FSM states, grant owners, byte-select width.
// Optional feature macro: RAM_ARB_FAIR_EN (round-robin instead of DATA-priority in IDLE).
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam int MEM_SEL            = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
  endfunction

endpackage

// File: rtl/ram_arb_timer.sv
// Wait-state counter for one BUSY episode; pulses timeout on the cycle the count
// reaches TIMEOUT_CYCLES-1 while the RAM is still not ready.
module ram_arb_timer
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/ram_arbiter.sv
// Serialises IF and MEM requests onto one single-port RAM with req/ready wait states.
// Define RAM_ARB_FAIR_EN for round-robin contention resolution; default is DATA priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_done,
  input  logic                  data_req,
  input  logic [MEM_SEL-1:0]    data_write_en,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_done,
  output logic                  bus_error,
  output logic                  stall_inst,
  output logic                  stall_data,
  output logic                  mem_req,
  output logic [MEM_SEL-1:0]    mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_SEL-1:0]    we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  err_q, err_d;
  logic                  grant;
  owner_e                grant_owner;
  logic                  tmr_en, tmr_timeout;

`ifdef RAM_ARB_FAIR_EN
  owner_e last_owner_q, last_owner_d;
`endif

  // Grant decision: IDLE arbitrates, RESP only hands off to the other requester.
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWNER_DATA;
    case (state_q)
      ST_IDLE: begin
        if (inst_req && data_req) begin
          grant = 1'b1;
`ifdef RAM_ARB_FAIR_EN
          grant_owner = other_owner(last_owner_q);
`else
          grant_owner = OWNER_DATA;
`endif
        end else if (data_req) begin
          grant       = 1'b1;
          grant_owner = OWNER_DATA;
        end else if (inst_req) begin
          grant       = 1'b1;
          grant_owner = OWNER_INST;
        end
      end
      ST_RESP: begin
        grant_owner = other_owner(owner_q);
        grant       = (owner_q == OWNER_INST) ? data_req : inst_req;
      end
      default: ;
    endcase
  end

  // Next state and request/response registers.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = grant ? ST_BUSY : ST_IDLE;
        if (grant) begin
          owner_d = grant_owner;
          if (grant_owner == OWNER_INST) begin
            addr_d  = inst_addr;
            we_d    = '0;
            wdata_d = '0;
          end else begin
            addr_d  = data_addr;
            we_d    = data_write_en;
            wdata_d = data_write_data;
          end
        end
      end
      ST_BUSY: begin
        // A ready in the timeout cycle still counts as a normal completion.
        if (mem_ready || tmr_timeout) begin
          state_d = ST_RESP;
          err_d   = !mem_ready;
          if (owner_q == OWNER_INST) inst_rdata_d = mem_ready ? mem_rdata : '0;
          else                       data_rdata_d = mem_ready ? mem_rdata : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RAM_ARB_FAIR_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if (grant) last_owner_d = grant_owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= OWNER_INST;
    else     last_owner_q <= last_owner_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_DATA;
      addr_q       <= '0;
      we_q         <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      err_q        <= err_d;
    end
  end

  assign tmr_en = (state_q == ST_BUSY) && !mem_ready;

  ram_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant),
    .en     (tmr_en),
    .timeout(tmr_timeout)
  );

  // RAM side comes only from registers so requester inputs never glitch onto the bus.
  always_comb begin
    mem_req   = (state_q == ST_BUSY);
    inst_done = (state_q == ST_RESP) && (owner_q == OWNER_INST);
    data_done = (state_q == ST_RESP) && (owner_q == OWNER_DATA);
    bus_error = (state_q == ST_RESP) && err_q;
  end

  assign mem_addr       = addr_q;
  assign mem_write_en   = we_q;
  assign mem_write_data = wdata_q;
  assign inst_rdata     = inst_rdata_q;
  assign data_rdata     = data_rdata_q;
  assign stall_inst     = inst_req && !inst_done;
  assign stall_data     = data_req && !data_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// scored against a shadow memory and a per-request completion bound.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic [3:0]  data_write_en;
  logic [31:0] data_addr;
  logic [31:0] data_write_data;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_error;
  logic        stall_inst;
  logic        stall_data;
  logic        mem_req;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] shadow_m [16];
  logic [31:0] ram_m    [16];

  ram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_write_en(data_write_en), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_rdata(data_rdata), .data_done(data_done),
    .bus_error(bus_error), .stall_inst(stall_inst), .stall_data(stall_data),
    .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({mem_req, inst_done, data_done, bus_error, stall_inst, stall_data} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, inst_done, data_done, bus_error, stall_inst, stall_data}); end
    checks++; if ({mem_addr, mem_write_en, mem_write_data, inst_rdata, data_rdata} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_write_en, mem_write_data, inst_rdata, data_rdata}); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1; inst_req = 1'b1; inst_addr = 32'h0000_0040;
    @(negedge clk);
    checks++; if ({stall_inst, mem_req} !== 2'b10) begin errors++; $display("FAIL sr_c0: got %b expected 10", {stall_inst, mem_req}); end
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'h2402_0001;
    @(negedge clk);
    checks++; if ({stall_inst, mem_req, inst_done, mem_write_en, mem_addr} !== {3'b110, 4'b0, 32'h40}) begin errors++; $display("FAIL sr_c1: got %h expected %h", {stall_inst, mem_req, inst_done, mem_write_en, mem_addr}, {3'b110, 4'b0, 32'h40}); end
    @(posedge clk); #1; mem_ready = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    checks++; if ({inst_done, bus_error, stall_inst, mem_req} !== 4'b1000) begin errors++; $display("FAIL sr_c2_ctrl: got %b expected 1000", {inst_done, bus_error, stall_inst, mem_req}); end
    checks++; if (inst_rdata !== 32'h2402_0001) begin errors++; $display("FAIL sr_c2_rdata: got %h expected 24020001", inst_rdata); end
    @(posedge clk); #1; inst_req = 1'b0;
    @(negedge clk);
    checks++; if ({inst_done, mem_req} !== 2'b00) begin errors++; $display("FAIL sr_c3: got %b expected 00", {inst_done, mem_req}); end
  endtask

  task automatic test_store_wait();
    @(posedge clk); #1;
    data_req = 1'b1; data_write_en = 4'b0100; data_addr = 32'h0000_1000; data_write_data = 32'h00AB_0000;
    @(negedge clk);
    checks++; if ({stall_data, mem_req} !== 2'b10) begin errors++; $display("FAIL st_c0: got %b expected 10", {stall_data, mem_req}); end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1; mem_ready = (c == 3); mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++; if ({mem_req, data_done, mem_write_en, mem_addr, mem_write_data} !== {2'b10, 4'b0100, 32'h1000, 32'h00AB_0000}) begin errors++; $display("FAIL st_busy%0d: got %h expected %h", c, {mem_req, data_done, mem_write_en, mem_addr, mem_write_data}, {2'b10, 4'b0100, 32'h1000, 32'h00AB_0000}); end
    end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({data_done, bus_error, stall_data, mem_req} !== 4'b1000) begin errors++; $display("FAIL st_c4: got %b expected 1000", {data_done, bus_error, stall_data, mem_req}); end
    @(posedge clk); #1; data_req = 1'b0; data_write_en = 4'b0;
    @(negedge clk);
    checks++; if ({data_done, mem_req} !== 2'b00) begin errors++; $display("FAIL st_c5: got %b expected 00", {data_done, mem_req}); end
  endtask

  // Both requesters arrive together; the winner depends on mode and on the prior store grant.
  task automatic test_contention();
    bit          fd;
    logic [31:0] a1, a2, r1, r2;
    logic [1:0]  d1, d2;
`ifdef RAM_ARB_FAIR_EN
    fd = 1'b0;
`else
    fd = 1'b1;
`endif
    a1 = fd ? 32'h200 : 32'h80;  a2 = fd ? 32'h80 : 32'h200;
    d1 = fd ? 2'b01 : 2'b10;     d2 = fd ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h80;
    data_req = 1'b1; data_addr = 32'h200; data_write_en = 4'b0;
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'h1111_AAAA;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, a1}) begin errors++; $display("FAIL ct_first_addr: got %h expected %h", {mem_req, mem_addr}, {1'b1, a1}); end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    r1 = fd ? data_rdata : inst_rdata;
    checks++; if ({inst_done, data_done, r1} !== {d1, 32'h1111_AAAA}) begin errors++; $display("FAIL ct_first_done: got %h expected %h", {inst_done, data_done, r1}, {d1, 32'h1111_AAAA}); end
    @(posedge clk); #1;
    if (fd) data_req = 1'b0; else inst_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h2222_BBBB;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, a2}) begin errors++; $display("FAIL ct_handoff: got %h expected %h", {mem_req, mem_addr}, {1'b1, a2}); end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    r2 = fd ? inst_rdata : data_rdata;
    checks++; if ({inst_done, data_done, r2} !== {d2, 32'h2222_BBBB}) begin errors++; $display("FAIL ct_second_done: got %h expected %h", {inst_done, data_done, r2}, {d2, 32'h2222_BBBB}); end
    @(posedge clk); #1; inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, inst_done, data_done} !== 3'b000) begin errors++; $display("FAIL ct_idle: got %b expected 000", {mem_req, inst_done, data_done}); end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1; inst_req = 1'b1; inst_addr = 32'h44;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; mem_ready = 1'b0;
      @(negedge clk);
      checks++; if ({mem_req, inst_done, bus_error} !== 3'b100) begin errors++; $display("FAIL to_busy%0d: got %b expected 100", c, {mem_req, inst_done, bus_error}); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({inst_done, bus_error, inst_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL to_done: got %h expected %h", {inst_done, bus_error, inst_rdata}, {2'b11, 32'h0}); end
    // Ready arriving in the very cycle the timeout would fire must win.
    @(posedge clk); #1; inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h208; data_write_en = 4'b0;
    @(negedge clk);
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b expected 0", bus_error); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; mem_ready = (c == 4); mem_rdata = 32'hC0DE_0004;
    end
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({data_done, bus_error, data_rdata} !== {2'b10, 32'hC0DE_0004}) begin errors++; $display("FAIL to_edge_ready: got %h expected %h", {data_done, bus_error, data_rdata}, {2'b10, 32'hC0DE_0004}); end
    @(posedge clk); #1; data_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1; data_req = 1'b1; data_addr = 32'h300; data_write_en = 4'b0;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy2: got %b expected 1", mem_req); end
    rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_async_drop: got %b expected 0", mem_req); end
    data_req = 1'b0;
    @(negedge clk);
    checks++; if ({data_done, inst_done, bus_error} !== 3'b000) begin errors++; $display("FAIL rm_no_done: got %b expected 000", {data_done, inst_done, bus_error}); end
    @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({mem_req, data_done, inst_done} !== 3'b000) begin errors++; $display("FAIL rm_after%0d: got %b expected 000", c, {mem_req, data_done, inst_done}); end
      @(posedge clk); #1;
    end
    data_req = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'h5A5A_0300;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({data_done, data_rdata} !== {1'b1, 32'h5A5A_0300}) begin errors++; $display("FAIL rm_reissue: got %h expected %h", {data_done, data_rdata}, {1'b1, 32'h5A5A_0300}); end
    @(posedge clk); #1; data_req = 1'b0;
  endtask

  task automatic test_spurious_ready();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_0000 + c;
      @(negedge clk);
      checks++; if ({mem_req, inst_done, data_done, bus_error, stall_inst, stall_data} !== 6'b0) begin errors++; $display("FAIL sp_idle%0d: got %b expected 000000", c, {mem_req, inst_done, data_done, bus_error, stall_inst, stall_data}); end
    end
    @(posedge clk); #1; mem_ready = 1'b0; inst_req = 1'b1; inst_addr = 32'h48;
    @(posedge clk); #1; mem_ready = 1'b1; mem_rdata = 32'h0D0D_0048;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    checks++; if ({inst_done, inst_rdata} !== {1'b1, 32'h0D0D_0048}) begin errors++; $display("FAIL sp_serve: got %h expected %h", {inst_done, inst_rdata}, {1'b1, 32'h0D0D_0048}); end
    @(posedge clk); #1; inst_req = 1'b0;
  endtask

  // Random traffic: a RAM responder with random wait states, scored against a shadow
  // memory that only changes when a store is reported done.
  task automatic test_random();
    int         i_age = 0, d_age = 0, wcnt = 0, n_i = 0, n_d = 0;
    bit         i_seen = 1'b0, d_seen = 1'b0;
    logic [3:0] ii, di, mi;
    for (int k = 0; k < 16; k++) begin shadow_m[k] = $urandom; ram_m[k] = shadow_m[k]; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (!inst_req || i_seen) begin
        i_seen = 1'b0; i_age = 0;
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!data_req || d_seen) begin
        d_seen = 1'b0; d_age = 0;
        data_req        = ($urandom_range(0, 2) != 0);
        data_addr       = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        data_write_en   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        data_write_data = $urandom;
      end
      if (mem_req) begin
        mi = mem_addr[5:2];
        if (wcnt >= 2 || $urandom_range(0, 1) == 1) begin
          mem_ready = 1'b1; mem_rdata = ram_m[mi];
          for (int b = 0; b < 4; b++) if (mem_write_en[b]) ram_m[mi][8*b +: 8] = mem_write_data[8*b +: 8];
          wcnt = 0;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom; wcnt++;
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0); mem_rdata = $urandom; wcnt = 0;
      end
      @(negedge clk);
      checks++; if ({stall_inst, stall_data} !== {inst_req && !inst_done, data_req && !data_done}) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", cyc, {stall_inst, stall_data}, {inst_req && !inst_done, data_req && !data_done}); end
      if (inst_done && data_done) begin checks++; errors++; $display("FAIL rnd_double_done cyc %0d: got 11 expected one-hot", cyc); end
      if (inst_done) begin
        ii = inst_addr[5:2];
        checks++; if ({bus_error, inst_rdata} !== {1'b0, shadow_m[ii]}) begin errors++; $display("FAIL rnd_inst cyc %0d: got %h expected %h", cyc, {bus_error, inst_rdata}, {1'b0, shadow_m[ii]}); end
        i_seen = 1'b1; n_i++;
      end
      if (data_done) begin
        di = data_addr[5:2];
        if (data_write_en == 4'd0) begin
          checks++; if ({bus_error, data_rdata} !== {1'b0, shadow_m[di]}) begin errors++; $display("FAIL rnd_load cyc %0d: got %h expected %h", cyc, {bus_error, data_rdata}, {1'b0, shadow_m[di]}); end
        end else begin
          checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rnd_store_err cyc %0d: got %b expected 0", cyc, bus_error); end
          for (int b = 0; b < 4; b++) if (data_write_en[b]) shadow_m[di][8*b +: 8] = data_write_data[8*b +: 8];
        end
        d_seen = 1'b1; n_d++;
      end
      if (inst_req && !i_seen && ++i_age > 16) begin checks++; errors++; i_seen = 1'b1; $display("FAIL rnd_inst_timeout cyc %0d: waited %0d cycles, limit 16", cyc, i_age); end
      if (data_req && !d_seen && ++d_age > 16) begin checks++; errors++; d_seen = 1'b1; $display("FAIL rnd_data_timeout cyc %0d: waited %0d cycles, limit 16", cyc, d_age); end
    end
    checks++; if (n_i < 20 || n_d < 20) begin errors++; $display("FAIL rnd_progress: got inst=%0d data=%0d expected >=20 each", n_i, n_d); end
    @(posedge clk); #1; inst_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_write_en = '0; data_addr = '0; data_write_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_single_read();
    test_store_wait();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_spurious_ready();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
